// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: PS/2 line inputs, pop/clear controls and FIFO/error status for ps2_rx_fifo.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int L = $clog2(FIFO_DEPTH + 1);
    logic         ps2_clk;
    logic         ps2_data;
    logic         samplen;
    logic         rden;
    logic         clr_ovf;
    logic [7:0]   q;
    logic         dsr;
    logic [L-1:0] level;
    logic         overflow;
    logic         err_parity;
    logic         err_frame;
    logic         err_timeout;
    modport master (
        output ps2_clk, ps2_data, samplen, rden, clr_ovf,
        input  q, dsr, level, overflow, err_parity, err_frame, err_timeout
    );
    modport slave (
        input  ps2_clk, ps2_data, samplen, rden, clr_ovf,
        output q, dsr, level, overflow, err_parity, err_frame, err_timeout
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch filter, frame checks and byte FIFO.
// Optional frame watchdog enabled by defining PS2RX_TIMEOUT_EN.
module ps2_rx_fifo #(
    parameter int         FILT_LEN    = 8,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] ERR_CODE    = 8'hFF,
    parameter int         TIMEOUT_CYC = 65535
) (
    input logic          clk,
    input logic          reset,
    ps2_rx_fifo_if.slave bus
);
    localparam int L  = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [FILT_LEN-1:0] hist_q, hist_d;
    logic                fclk_q, fclk_d, ce_q;
    state_t              state_q, state_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic [9:0]          sh_q, sh_d;
    logic                push, par_ok, stop_ok, tmo;
    logic [7:0]          wdata;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wp_q, rp_q;
    logic [L-1:0]        cnt_q, cnt_d;
    logic [7:0]          q_q;
    logic                pop, full, wr, ovf_q, ovf_d, errp_q, errf_q;

    // Filtered clock only changes once the whole history agrees
    always_comb begin
        hist_d = bus.samplen ? {hist_q[FILT_LEN-2:0], bus.ps2_clk} : hist_q;
        fclk_d = (&hist_q) ? 1'b1 : (~|hist_q) ? 1'b0 : fclk_q;
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sh_d     = sh_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce_q && !bus.ps2_data) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd0;
                end
            end
            RECV: begin
                if (ce_q) begin
                    sh_d     = {bus.ps2_data, sh_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    state_d  = (bitcnt_q == 4'd9) ? CHECK : RECV;
                end else if (tmo) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        par_ok  = ^sh_q[8:0];
        stop_ok = sh_q[9];
        wdata   = (par_ok && stop_ok) ? sh_q[7:0] : ERR_CODE;
        pop     = bus.rden && (cnt_q != '0);
        full    = cnt_q == L'(FIFO_DEPTH);
        wr      = push && (!full || pop);
        cnt_d   = cnt_q + L'(wr) - L'(pop);
        ovf_d   = (push && full && !pop) || (ovf_q && !bus.clr_ovf);
    end

`ifdef PS2RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          errt_q;

    // Watchdog restarts on every accepted clock edge while a frame is open
    always_comb begin
        tcnt_d = (state_q != RECV || ce_q) ? '0 : tcnt_q + TW'(1);
        tmo    = (state_q == RECV) && !ce_q && (tcnt_q == TW'(TIMEOUT_CYC));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            errt_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            errt_q <= tmo;
        end
    end

    assign bus.err_timeout = errt_q;
`else
    assign tmo             = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q   <= '1;
            fclk_q   <= 1'b1;
            ce_q     <= 1'b0;
            state_q  <= IDLE;
            bitcnt_q <= 4'd0;
            sh_q     <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            ovf_q    <= 1'b0;
            errp_q   <= 1'b0;
            errf_q   <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            fclk_q   <= fclk_d;
            ce_q     <= fclk_q && !fclk_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sh_q     <= sh_d;
            wp_q     <= wr ? wp_q + AW'(1) : wp_q;
            rp_q     <= pop ? rp_q + AW'(1) : rp_q;
            cnt_q    <= cnt_d;
            q_q      <= pop ? mem[rp_q] : q_q;
            ovf_q    <= ovf_d;
            errp_q   <= push && !par_ok;
            errf_q   <= push && !stop_ok;
        end
    end

    // Storage needs no reset: the pointers and count define validity
    always_ff @(posedge clk) begin
        if (!reset && wr) mem[wp_q] <= wdata;
    end

    assign bus.q          = q_q;
    assign bus.dsr        = cnt_q != '0;
    assign bus.level      = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.err_parity = errp_q;
    assign bus.err_frame  = errf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames against a byte scoreboard and bench-side level/overflow model.
module tb_ps2_rx_fifo;
    localparam int H = 40;
`ifdef PS2RX_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   np = 0, nf = 0, nt = 0;
    int   mlevel = 0;
    int   exp_ovf = 0;
    logic [7:0] exp_q [$];

    ps2_rx_fifo_if #(.FIFO_DEPTH(8)) bus ();

    ps2_rx_fifo #(.FILT_LEN(8), .FIFO_DEPTH(8), .ERR_CODE(8'hFF), .TIMEOUT_CYC(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial bus.samplen = 1'b0;
    always @(negedge clk) bus.samplen = ~bus.samplen;

    always @(posedge clk) begin
        if (!reset) begin
            if (bus.err_parity)  np <= np + 1;
            if (bus.err_frame)   nf <= nf + 1;
            if (bus.err_timeout) nt <= nt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge clk) bus.ps2_data = b;
        if (glitch) begin
            repeat (15) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (13) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (25) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
        bus.ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int glitch_at, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == glitch_at);
        if (nbits == 11) begin
            if (mlevel == 8) exp_ovf = 1;
            else begin
                exp_q.push_back((bad_par || bad_stop) ? 8'hFF : d);
                mlevel++;
            end
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic pop(input string tag);
        int k;
        logic [7:0] e;
        k = 0;
        while (!bus.dsr && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_dsr"}, bus.dsr, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        bus.rden = 1'b1;
        @(negedge clk) bus.rden = 1'b0;
        if (mlevel > 0) mlevel--;
        chk({tag, "_q"}, bus.q, e);
        chk({tag, "_level"}, bus.level, mlevel);
    endtask

    initial begin
        int p0, f0, t0, k;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        bus.rden = 1'b0;
        bus.clr_ovf = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_q", bus.q, 0);
        chk("rst_dsr", bus.dsr, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_errs", {bus.err_parity, bus.err_frame, bus.err_timeout}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // valid frame, then pop
        send_frame(8'h1C, 0, 0, -1, 11);
        chk("t1_dsr", bus.dsr, 1);
        chk("t1_level", bus.level, 1);
        pop("t1");
        chk("t1_dsr_empty", bus.dsr, 0);
        bus.rden = 1'b1;
        @(negedge clk) bus.rden = 1'b0;
        chk("t1_pop_empty_q", bus.q, 8'h1C);
        chk("t1_pop_empty_level", bus.level, 0);

        // parity error
        p0 = np; f0 = nf;
        send_frame(8'h1C, 1, 0, -1, 11);
        pop("t2");
        chk("t2_par_pulses", np - p0, 1);
        chk("t2_frm_pulses", nf - f0, 0);

        // stop-bit error
        p0 = np; f0 = nf;
        send_frame(8'h33, 0, 1, -1, 11);
        pop("t2b");
        chk("t2b_par_pulses", np - p0, 0);
        chk("t2b_frm_pulses", nf - f0, 1);

        // overflow
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, -1, 11);
        chk("t3_ovf", bus.overflow, exp_ovf);
        chk("t3_level", bus.level, 8);
        for (int i = 0; i < 8; i++) pop("t3");
        chk("t3_ovf_sticky", bus.overflow, 1);
        bus.clr_ovf = 1'b1;
        @(negedge clk) bus.clr_ovf = 1'b0;
        chk("t3_ovf_clr", bus.overflow, 0);

        // clock glitch inside a frame
        send_frame(8'h5A, 0, 0, 3, 11);
        chk("t4_level", bus.level, 1);
        pop("t4");

        // reset mid-frame
        p0 = np; f0 = nf;
        send_frame(8'hA5, 0, 0, -1, 6);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mlevel = 0;
        chk("t5_rst_level", bus.level, 0);
        chk("t5_rst_q", bus.q, 0);
        repeat (20) @(negedge clk);
        send_frame(8'hF0, 0, 0, -1, 11);
        chk("t5_level", bus.level, 1);
        pop("t5");
        chk("t5_no_errs", (np - p0) + (nf - f0) + nt, 0);

`ifdef PS2RX_TIMEOUT_EN
        t0 = nt;
        send_frame(8'h00, 0, 0, -1, 5);
        k = 0;
        while (nt == t0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("t6_timeout", nt - t0, 1);
        chk("t6_level", bus.level, 0);
        repeat (20) @(negedge clk);
        send_frame(8'h12, 0, 0, -1, 11);
        pop("t6");
`else
        t0 = 0;
        k = 0;
        chk("t6_timeout_tied", bus.err_timeout, t0 + k);
`endif

        chk("end_scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
